// File: rtl/conv_frame_encoder_if.sv
// Frame-level handshake and result bus of the convolutional frame encoder.
// The master issues frames; the slave (encoder) returns symbols and traces.
interface conv_frame_encoder_if #(
   parameter int FRAME_LEN = 11,
   parameter int NS_STEPS  = 13,
   parameter int SW        = 2
) ();

   logic                     Start;
   logic [FRAME_LEN-1:0]     Data_In;
   logic                     Busy;
   logic                     Done;
   logic [1:0]               Y_Out;
   logic                     Y_Valid;
   logic [2*NS_STEPS-1:0]    Encoded_Out;
   logic [SW*NS_STEPS-1:0]   PS_Out;
   logic [SW*NS_STEPS-1:0]   NS_Out;

   modport master (
      output Start, Data_In,
      input  Busy, Done, Y_Out, Y_Valid, Encoded_Out, PS_Out, NS_Out
   );

   modport slave (
      input  Start, Data_In,
      output Busy, Done, Y_Out, Y_Valid, Encoded_Out, PS_Out, NS_Out
   );

endinterface

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 feedforward convolutional encoder: encodes one parallel frame LSB
// first from the zero state, optionally terminated with K-1 zero tail bits.
module conv_frame_encoder #(
   parameter int             FRAME_LEN = 11,
   parameter int             K         = 3,
   parameter logic [K-1:0]   G0        = 3'b111,
   parameter logic [K-1:0]   G1        = 3'b101,
   parameter int             TAIL      = 1,
   localparam int            SW        = K - 1,
   localparam int            NS_STEPS  = FRAME_LEN + TAIL * (K - 1)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   conv_frame_encoder_if.slave   bus
);

   // One extra count bit keeps the counter at least one bit wide for 1-step frames.
   localparam int CW = $clog2(NS_STEPS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                fsm;
   logic [FRAME_LEN-1:0]  data_sh;
   logic [SW-1:0]         enc_state;
   logic [CW-1:0]         step;

   logic [K-1:0]          v;
   logic                  y0;
   logic                  y1;
   logic                  last_step;

   // The frame shifts right each step, so zeros enter from the top and
   // supply the tail bits without a separate multiplexer.
   always_comb begin
      v         = {data_sh[0], enc_state};
      y0        = ^(v & G0);
      y1        = ^(v & G1);
      last_step = (step == CW'(NS_STEPS - 1));
   end

   // NOTE: every register here is updated with <= so all of them sample the
   // pre-edge values of each other; the trace registers are plain flops (not a
   // memory), so clearing them on reset is legal and cheap.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         fsm             <= S_IDLE;
         data_sh         <= '0;
         enc_state       <= '0;
         step            <= '0;
         bus.Busy        <= 1'b0;
         bus.Done        <= 1'b0;
         bus.Y_Out       <= 2'b00;
         bus.Y_Valid     <= 1'b0;
         bus.Encoded_Out <= '0;
         bus.PS_Out      <= '0;
         bus.NS_Out      <= '0;
      end else begin
         bus.Y_Valid <= 1'b0;
         bus.Done    <= 1'b0;
         case (fsm)
            S_IDLE: begin
               if (bus.Start) begin
                  data_sh         <= bus.Data_In;
                  enc_state       <= '0;
                  step            <= '0;
                  bus.Encoded_Out <= '0;
                  bus.PS_Out      <= '0;
                  bus.NS_Out      <= '0;
                  bus.Busy        <= 1'b1;
                  fsm             <= S_RUN;
               end
            end

            S_RUN: begin
               bus.Encoded_Out[2*int'(step) +: 2] <= {y0, y1};
               bus.PS_Out[SW*int'(step) +: SW]    <= enc_state;
               bus.NS_Out[SW*int'(step) +: SW]    <= v[K-1:1];
               bus.Y_Out                          <= {y0, y1};
               bus.Y_Valid                        <= 1'b1;
               enc_state                          <= v[K-1:1];
               data_sh                            <= data_sh >> 1;
               if (last_step) begin
                  bus.Done <= 1'b1;
                  fsm      <= S_DONE;
               end else begin
                  step <= step + 1'b1;
               end
            end

            S_DONE: begin
               bus.Busy <= 1'b0;
               fsm      <= S_IDLE;
            end

            default: fsm <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/conv_frame_encoder.md
Name: conv_frame_encoder

Overview:
Parametrised rate-1/2 feedforward convolutional encoder with frame handshake. It encodes a FRAME_LEN-bit parallel word serially, LSB first, from the zero state. It optionally appends K-1 zero tail bits to terminate the trellis. It returns the packed encoded frame plus per-step present/next state traces for the downstream Viterbi decoder and its checker, and streams each symbol as it is produced.

Parameters:
FRAME_LEN, 11, data bits per frame (1..64)
K, 3, constraint length (2..7); state width SW = K-1
G0, 3'b111, generator for Y0, K bits, MSB taps current input; MSB must be 1
G1, 3'b101, generator for Y1, same rules
TAIL, 1, 1 = append K-1 zero tail bits, 0 = no termination
(derived) NS_STEPS = FRAME_LEN + TAIL*(K-1)

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  synchronous, active-high reset
Start  in  1  frame request; accepted only in IDLE
Data_In  in  FRAME_LEN  frame; bit 0 is encoded first; sampled on the accepting edge only
Busy  out  1  high in RUN and DONE
Done  out  1  one-cycle pulse; frame outputs complete
Y_Out  out  2  streaming symbol {Y0,Y1} of the step just taken
Y_Valid  out  1  high for one cycle per encoded step
Encoded_Out  out  2*NS_STEPS  slot n = [2n+1:2n] = {Y0,Y1} of step n
PS_Out  out  SW*NS_STEPS  slot n = [SW*n+SW-1:SW*n] = state before step n
NS_Out  out  SW*NS_STEPS  slot n = state after step n

Behaviour:
- Reset: FSM=IDLE; state register, step counter, and all outputs = 0. Applies mid-frame: the frame is abandoned and no Done is generated.
- FSM: IDLE -(Start)-> RUN -(step NS_STEPS-1 done)-> DONE -> IDLE. Start in RUN or DONE is ignored and not queued.
- Accept edge t0 (IDLE & Start):
  - latch Data_In, state S=0, counter n=0
  - clear Encoded_Out, PS_Out, NS_Out to 0
- Each RUN cycle, step n is written at edge t0+1+n:
  - x = Data_In[n] for n<FRAME_LEN, else 0 (tail)
  - V = {x, S} (K bits, V[K-1]=x, S[SW-1] is the most recent past bit)
  - Y0 = XOR-reduce(V & G0); Y1 = XOR-reduce(V & G1)
  - NS = V[K-1:1]
  - write slot n of all three traces; Y_Out={Y0,Y1}, Y_Valid=1; S<=NS; n<=n+1
- Latency and handshake:
  - first symbol is registered one cycle after acceptance
  - Done=1 in the cycle after edge t0+NS_STEPS (the DONE state), Y_Valid=0 there
  - Busy falls when returning to IDLE; earliest next accept is the edge after Done
- Outputs hold their last values in IDLE until the next accept. Y_Out holds its last value; Y_Valid=0 whenever not stepping.
- With TAIL=1 the final NS slot is always 0. With TAIL=0 the final state is arbitrary.
- Rst and Start asserted together: reset wins.
- All arithmetic is XOR/shift; no counter wrap because n stops at NS_STEPS-1.

Test Plan:
- FRAME_LEN=4, K=3, G0=7, G1=5, TAIL=1, Data_In=4'b1101 -> symbols 11,10,00,01,01,11; Encoded_Out=12'hD4B, PS_Out=12'h798, NS_Out=12'h1E6; Done exactly 7 cycles after the accept edge; Y_Valid high for 6 cycles.
- Default parameters, Data_In=0 -> Encoded_Out, PS_Out, NS_Out all 0; Done after 14 cycles; Busy high 14 cycles.
- Same as the first scenario with TAIL=0 -> Encoded_Out=8'h4B, NS_Out last slot=2'b11, Done 5 cycles after accept.
- Start pulsed during RUN and during DONE -> ignored, outputs unchanged; Start on the first IDLE cycle -> accepted, traces cleared the same edge.
- Rst asserted at step 2 of a frame -> next cycle all outputs 0, FSM IDLE, no Done; a subsequent frame encodes correctly from state 0.
- Random Data_In, K=5, G0=5'b10011, G1=5'b11101, 200 frames -> bit-exact match to a reference model; every final NS slot = 0.
